queue_param: RTL
================

Name: queue_param

Overview:
- Parametrised synchronous FIFO queue. Next generation of the 8-entry byte queue, generalised in data width and depth.
- Adds a selectable overflow policy: drop the new entry, or overwrite the oldest entry.
- Adds empty, overflow and underflow indications.
- Sits between the deserialiser byte assembler and the downstream consumer, in the 10 kHz clock domain.

Parameters:
- DATA_W, 8: data word width in bits.
- DEPTH, 8: number of entries; power of two, minimum 2.
- MODE, Q_DROP: overflow policy of type queue_mode_t. Q_DROP discards the incoming word; Q_OVERWRITE replaces the oldest word.

Ports:
- clock_10k  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset.
- data_in  input  DATA_W  word to enqueue.
- enq_in  input  1  enqueue request; level-sampled every rising edge.
- deq_in  input  1  dequeue request; level-sampled every rising edge.
- data_out  output  DATA_W  head (oldest) entry, first-word-fall-through; all zeros when empty.
- len_out  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- status_out  output  1  full flag: 1 when len_out == DEPTH.
- empty_out  output  1  1 when len_out == 0.
- ovf_out  output  1  one-cycle pulse the cycle after an enqueue is requested while full.
- udf_out  output  1  one-cycle pulse the cycle after a dequeue is requested while empty.

Behaviour:
- Reset (reset == 0 at a rising edge): head = tail = 0, len_out = 0, empty_out = 1, status_out = 0, ovf_out = udf_out = 0, data_out = 0.
  - Storage contents are not cleared.
  - Reset overrides any enq_in/deq_in sampled in the same cycle.
- State: head pointer, tail pointer (log2 DEPTH bits, natural wrap-around), len counter. Pointer wrap from DEPTH-1 to 0 is silent.
- Latency:
  - A word enqueued into an empty queue appears on data_out the cycle after the edge.
  - Dequeue advances data_out to the next entry the cycle after the edge.
- Not full, enq only: write mem[tail] = data_in; tail++, len++.
- Not empty, deq only: head++, len--.
- enq and deq together, 0 < len < DEPTH: write and pop in the same edge; len unchanged.
- Empty:
  - deq only: ignored, udf_out pulses.
  - enq and deq together: enqueue only, len becomes 1, udf_out pulses.
- Full:
  - enq and deq together: both succeed, len stays DEPTH, no ovf pulse.
  - enq only, Q_DROP: data_in discarded; head, tail and len unchanged; ovf_out pulses.
  - enq only, Q_OVERWRITE: write mem[tail]; tail++, head++; len stays DEPTH; ovf_out pulses; data_out shows the new oldest word.
- Flags are combinational decodes of len; ovf_out and udf_out are registered.
- No X propagation: data_out is forced to zero when empty.

Decomposition:
- queue_pkg holds typedef enum queue_mode_t {Q_DROP, Q_OVERWRITE} and a helper function ptr_w(depth) returning $clog2(depth).
- Sub-module queue_ram holds the storage array: DEPTH x DATA_W, one synchronous write port, one asynchronous read port (waddr, we, wdata, raddr, rdata).
- Pointer, length and flag control stay in queue_param.

Test Plan (DEPTH=8, DATA_W=8):
- Reset: hold reset=0 for 2 cycles -> len_out=0, empty_out=1, status_out=0, data_out=00, ovf_out=udf_out=0.
- Q_DROP fill: 9 single-cycle enqueues of 11,22,...,99 -> len_out=8, status_out=1, ovf_out pulses once on the 9th, data_out=11. Then 5 dequeues -> len_out=3, data_out=66.
- Q_DROP wrap-around: from len 3 (66,77,88), enqueue AA,BB,CC,DD,EE,FF,10:
  - len_out=8 after FF; ovf_out pulses for FF and 10.
  - Draining yields 66,77,88,AA,BB,CC,DD,EE.
- Q_OVERWRITE fill: 9 enqueues 11..99 -> len_out=8, ovf_out pulses once, data_out=22. Draining yields 22..99, then empty_out=1 and data_out=00.
- Simultaneous events:
  - Full with enq and deq together (data 5A) -> len_out stays 8, head advances, 5A is read last.
  - Empty with deq only -> udf_out pulse, len_out=0.
  - Empty with enq(3C) and deq together -> len_out=1, data_out=3C, udf_out pulse.
- Reset mid-operation: at len 5, drive reset=0 for 1 cycle together with enq_in=1 -> len_out=0, empty_out=1, no write. Next enqueue 77 -> data_out=77.

Source files
------------

// File: rtl/queue_pkg.sv
// Shared types and helpers for the parametrised queue.
package queue_pkg;

    typedef enum logic {Q_DROP, Q_OVERWRITE} queue_mode_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/queue_ram.sv
// Queue storage: one synchronous write port, one asynchronous read port.
module queue_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int AW     = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/queue_param.sv
// Parametrised first-word-fall-through FIFO with drop/overwrite overflow policy
// and registered overflow/underflow pulses.
module queue_param
    import queue_pkg::*;
#(
    parameter int          DATA_W = 8,
    parameter int          DEPTH  = 8,
    parameter queue_mode_t MODE   = Q_DROP
) (
    input  logic                       clock_10k,
    input  logic                       reset,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       enq_in,
    input  logic                       deq_in,
    output logic [DATA_W-1:0]          data_out,
    output logic [$clog2(DEPTH+1)-1:0] len_out,
    output logic                       status_out,
    output logic                       empty_out,
    output logic                       ovf_out,
    output logic                       udf_out
);

    localparam int PW = ptr_w(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [PW-1:0]     head, tail;
    logic [LW-1:0]     len;
    logic              full, empty, do_wr, do_pop;
    logic [DATA_W-1:0] rdata;

    assign full  = (len == LW'(DEPTH));
    assign empty = (len == '0);

    // When full, a lone enqueue either gets dropped or pushes out the oldest word.
    assign do_wr  = enq_in && (!full || deq_in || (MODE == Q_OVERWRITE));
    assign do_pop = (deq_in && !empty) ||
                    (enq_in && !deq_in && full && (MODE == Q_OVERWRITE));

    queue_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(PW)) u_ram (
        .clk   (clock_10k),
        .we    (do_wr && reset),
        .waddr (tail),
        .wdata (data_in),
        .raddr (head),
        .rdata (rdata)
    );

    always_ff @(posedge clock_10k) begin
        if (!reset) begin
            head    <= '0;
            tail    <= '0;
            len     <= '0;
            ovf_out <= 1'b0;
            udf_out <= 1'b0;
        end else begin
            if (do_wr)  tail <= tail + PW'(1);
            if (do_pop) head <= head + PW'(1);
            if (do_wr && !do_pop)      len <= len + LW'(1);
            else if (!do_wr && do_pop) len <= len - LW'(1);
            ovf_out <= enq_in && !deq_in && full;
            udf_out <= deq_in && empty;
        end
    end

    assign data_out   = empty ? '0 : rdata;
    assign len_out    = len;
    assign status_out = full;
    assign empty_out  = empty;

endmodule
